// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared types and AHB-Lite encodings for the read/write scheduler
package ahb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    RD_A,
    RD_D,
    WR_A,
    WR_D,
    FIN,
    ERR
  } state_t;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } grant_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  // Byte writes are presented on every lane so the slave can pick any address offset
  function automatic logic [31:0] replicate_byte(input logic [7:0] b);
    return {4{b}};
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-requester round-robin arbiter with an explicit last-grant register
module rr_arbiter2
  import ahb_pkg::*;
(
  input  logic   HCLK,
  input  logic   HRESETn,
  input  logic   init,
  input  logic   req_rd,
  input  logic   req_wr,
  input  logic   upd_en,
  input  grant_t upd_grant,
  output logic   gnt_valid,
  output grant_t gnt
);

  grant_t last_grant;

  // last_grant starts at WR so the first contended grant goes to a read
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      last_grant <= WR;
    end else if (init) begin
      last_grant <= WR;
    end else if (upd_en) begin
      last_grant <= upd_grant;
    end
  end

  // Grant the side that did not win last time when both ask
  always_comb begin
    gnt_valid = req_rd || req_wr;
    gnt       = RD;
    if (req_rd && req_wr) begin
      gnt = (last_grant == RD) ? WR : RD;
    end else if (req_wr) begin
      gnt = WR;
    end
  end

endmodule

// File: rtl/ahb_rw_scheduler.sv
// rtl/ahb_rw_scheduler.sv - shares one AHB-Lite master port between pixel reads and result writes
module ahb_rw_scheduler
  import ahb_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             start,
  input  logic [31:0]      rd_addr,
  input  logic             end_of_image,
  output logic             addr_update_enable_r,
  input  logic             pix_full,
  output logic             pix_valid,
  output logic [PIX_W-1:0] pix_data,
  input  logic             wr_req,
  input  logic [31:0]      wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  output logic             wr_ack,
  input  logic             proc_busy,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [31:0]      HWDATA,
  input  logic [31:0]      HRDATA,
  input  logic             HREADY,
  input  logic             HRESP,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      rd_count,
  output logic [31:0]      wr_count
);

  state_t      state_q;
  state_t      state_d;
  logic        rd_done;
  logic [1:0]  lane;
  logic        rd_fire;
  logic        wr_fire;
  logic        init;
  logic        rd_elig;
  logic        wr_elig;
  logic        gnt_valid;
  grant_t      gnt;

  assign init    = ((state_q == IDLE) || (state_q == ERR)) && start;
  assign rd_elig = !rd_done && !pix_full;
  // wr_ack is still high in the ARB cycle right after a write, before the
  // requester has had a chance to drop or advance wr_req; masking it there
  // stops the same result from being written twice.
  assign wr_elig = wr_req && !wr_ack;

  rr_arbiter2 u_arb (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .init      (init),
    .req_rd    (rd_elig),
    .req_wr    (wr_elig),
    .upd_en    (rd_fire || wr_fire),
    .upd_grant (rd_fire ? RD : WR),
    .gnt_valid (gnt_valid),
    .gnt       (gnt)
  );

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode plus completion qualifiers for the data phases
  always_comb begin
    state_d = state_q;
    rd_fire = 1'b0;
    wr_fire = 1'b0;
    case (state_q)
      IDLE, ERR: begin
        if (start) state_d = ARB;
      end
      ARB: begin
        if (gnt_valid) begin
          state_d = (gnt == RD) ? RD_A : WR_A;
        end else if (rd_done && !proc_busy) begin
          state_d = FIN;
        end
      end
      RD_A: begin
        if (HREADY) state_d = RD_D;
      end
      RD_D: begin
        if (HRESP != HRESP_OKAY) begin
          state_d = ERR;
        end else if (HREADY) begin
          state_d = ARB;
          rd_fire = 1'b1;
        end
      end
      WR_A: begin
        if (HREADY) state_d = WR_D;
      end
      WR_D: begin
        if (HRESP == HRESP_ERROR) begin
          state_d = ERR;
        end else if (HREADY) begin
          state_d = ARB;
          wr_fire = 1'b1;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address-phase outputs decoded straight from state so rd_addr updates are picked up immediately
  always_comb begin
    HTRANS = HTRANS_IDLE;
    HADDR  = '0;
    HWRITE = 1'b0;
    HSIZE  = HSIZE_BYTE;
    case (state_q)
      RD_A: begin
        HTRANS = HTRANS_NONSEQ;
        HADDR  = rd_addr;
      end
      WR_A: begin
        HTRANS = HTRANS_NONSEQ;
        HADDR  = wr_addr;
        HWRITE = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered strobes, status, operand latches and counters
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pix_valid            <= 1'b0;
      addr_update_enable_r <= 1'b0;
      wr_ack               <= 1'b0;
      done                 <= 1'b0;
      busy                 <= 1'b0;
      err                  <= 1'b0;
      rd_done              <= 1'b0;
      lane                 <= 2'b00;
      pix_data             <= '0;
      HWDATA               <= '0;
      rd_count             <= '0;
      wr_count             <= '0;
    end else begin
      pix_valid            <= 1'b0;
      addr_update_enable_r <= 1'b0;
      wr_ack               <= 1'b0;
      done                 <= (state_q == FIN);
      busy                 <= (state_d != IDLE) && (state_d != ERR);
      err                  <= (state_d == ERR);
      if (init) begin
        rd_done  <= 1'b0;
        rd_count <= '0;
        wr_count <= '0;
      end
      if ((state_q == RD_A) && HREADY) begin
        lane <= rd_addr[1:0];
      end
      if ((state_q == WR_A) && HREADY) begin
        HWDATA <= replicate_byte(wr_data);
      end
      if (rd_fire) begin
        pix_data  <= HRDATA[{lane, 3'b000} +: PIX_W];
        pix_valid <= 1'b1;
        rd_count  <= rd_count + 32'd1;
        if (end_of_image) begin
          rd_done <= 1'b1;
        end else begin
          addr_update_enable_r <= 1'b1;
        end
      end
      if (wr_fire) begin
        wr_ack   <= 1'b1;
        wr_count <= wr_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_ahb_rw_scheduler.sv
// tb/tb_ahb_rw_scheduler.sv - directed self-checking bench for ahb_rw_scheduler
module tb_ahb_rw_scheduler;
  import ahb_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b1;
  logic        start;
  logic [31:0] rd_addr;
  logic        end_of_image;
  logic        addr_update_enable_r;
  logic        pix_full;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack;
  logic        proc_busy;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rd_count;
  logic [31:0] wr_count;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_rw_scheduler #(.PIX_W(8)) dut (
    .HCLK                 (HCLK),
    .HRESETn              (HRESETn),
    .start                (start),
    .rd_addr              (rd_addr),
    .end_of_image         (end_of_image),
    .addr_update_enable_r (addr_update_enable_r),
    .pix_full             (pix_full),
    .pix_valid            (pix_valid),
    .pix_data             (pix_data),
    .wr_req               (wr_req),
    .wr_addr              (wr_addr),
    .wr_data              (wr_data),
    .wr_ack               (wr_ack),
    .proc_busy            (proc_busy),
    .HADDR                (HADDR),
    .HTRANS               (HTRANS),
    .HWRITE               (HWRITE),
    .HSIZE                (HSIZE),
    .HWDATA               (HWDATA),
    .HRDATA               (HRDATA),
    .HREADY               (HREADY),
    .HRESP                (HRESP),
    .busy                 (busy),
    .done                 (done),
    .err                  (err),
    .rd_count             (rd_count),
    .wr_count             (wr_count)
  );

  task automatic tick();
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  task automatic set_defaults();
    start        = 1'b0;
    rd_addr      = 32'h0;
    end_of_image = 1'b0;
    pix_full     = 1'b0;
    wr_req       = 1'b0;
    wr_addr      = 32'h0;
    wr_data      = 8'h0;
    proc_busy    = 1'b0;
    HRDATA       = 32'h0;
    HREADY       = 1'b1;
    HRESP        = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    set_defaults();
    @(negedge HCLK);
    #1 HRESETn = 1'b0;
    repeat (2) @(negedge HCLK);
    checks++;
    if ({busy, done, err, pix_valid, addr_update_enable_r, wr_ack} !== 6'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 000000", {busy, done, err, pix_valid, addr_update_enable_r, wr_ack});
    end
    checks++;
    if ({HTRANS, HWRITE, HSIZE} !== 6'b0 || HADDR !== 32'h0 || HWDATA !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: got htrans=%h hwrite=%b hsize=%h haddr=%h hwdata=%h expected all 0", HTRANS, HWRITE, HSIZE, HADDR, HWDATA);
    end
    checks++;
    if (pix_data !== 8'h0 || rd_count !== 32'h0 || wr_count !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got pix=%h rd=%0d wr=%0d expected 0 0 0", pix_data, rd_count, wr_count);
    end
    HRESETn = 1'b1;
    repeat (2) tick();
    checks++;
    if (busy !== 1'b0 || HTRANS !== HTRANS_IDLE) begin
      errors++;
      $display("FAIL reset_stays_idle: got busy=%b htrans=%h expected 0 0", busy, HTRANS);
    end
  endtask

  task automatic test_single_read();
    int nonseq = 0, pv = 0, pv_c = -1, done_c = -1, upd = 0;
    logic [31:0] a_seen = 32'h0;
    logic        w_seen = 1'b0;
    logic [7:0]  pd = 8'h0;
    set_defaults();
    rd_addr      = 32'h1000_0002;
    end_of_image = 1'b1;
    HRDATA       = 32'h4433_2211;
    pulse_start();
    for (int c = 0; c < 20 && done_c < 0; c++) begin
      if (HTRANS == HTRANS_NONSEQ) begin nonseq++; a_seen = HADDR; w_seen = HWRITE; end
      if (pix_valid) begin pv++; pv_c = c; pd = pix_data; end
      if (addr_update_enable_r) upd++;
      if (done) done_c = c;
      tick();
    end
    checks++;
    if (nonseq != 1 || a_seen !== 32'h1000_0002 || w_seen !== 1'b0) begin
      errors++;
      $display("FAIL single_nonseq: got n=%0d addr=%h write=%b expected 1 10000002 0", nonseq, a_seen, w_seen);
    end
    checks++;
    if (pv != 1 || pd !== 8'h33 || pv_c != 3) begin
      errors++;
      $display("FAIL single_pixel: got n=%0d data=%h cyc=%0d expected 1 33 3", pv, pd, pv_c);
    end
    checks++;
    if (upd != 0) begin
      errors++;
      $display("FAIL single_no_update: got %0d pulses expected 0", upd);
    end
    checks++;
    if (done_c != 5) begin
      errors++;
      $display("FAIL single_done_timing: got cycle %0d expected 5", done_c);
    end
    checks++;
    if (rd_count !== 32'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_end_state: got rd=%0d busy=%b expected 1 0", rd_count, busy);
    end
  endtask

  task automatic test_contention();
    logic        seq [8];
    int          n = 0, wr_ns = 0, acks = 0, k = 0, ra_err = 0, wa_err = 0, wd_err = 0, seq_err = 0;
    bit          seen_done = 1'b0, chk_wd = 1'b0;
    logic [31:0] exp_wd = 32'h0;
    logic [31:0] exp_ra = 32'h100;
    set_defaults();
    rd_addr = 32'h100;
    wr_req  = 1'b1;
    wr_addr = 32'h2000_0000;
    wr_data = 8'h10;
    pulse_start();
    for (int c = 0; c < 80 && !seen_done; c++) begin
      if (chk_wd) begin
        if (HWDATA !== exp_wd) wd_err++;
        chk_wd = 1'b0;
      end
      if (HTRANS == HTRANS_NONSEQ) begin
        if (n < 8) seq[n] = HWRITE;
        n++;
        if (HWRITE) begin
          wr_ns++;
          if (HADDR !== wr_addr) wa_err++;
          exp_wd = {4{wr_data}};
          chk_wd = 1'b1;
        end else if (HADDR !== exp_ra) begin
          ra_err++;
        end
        if (n == 6) begin wr_req = 1'b0; end_of_image = 1'b1; end
      end
      if (addr_update_enable_r) begin exp_ra = exp_ra + 32'd1; rd_addr = exp_ra; end
      if (wr_ack) begin
        acks++;
        k++;
        wr_addr = 32'h2000_0000 + 32'(k);
        wr_data = 8'(16 + k);
      end
      if (done) seen_done = 1'b1;
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      if (i >= n || seq[i] !== 1'(i % 2)) seq_err++;
    end
    checks++;
    if (seq_err != 0) begin
      errors++;
      $display("FAIL contention_order: got %0d slots out of RD,WR,RD,WR,RD,WR order expected 0", seq_err);
    end
    checks++;
    if (wr_ns != 3 || acks != wr_ns) begin
      errors++;
      $display("FAIL contention_acks: got nonseq_wr=%0d acks=%0d expected 3 3", wr_ns, acks);
    end
    checks++;
    if (ra_err != 0 || wa_err != 0 || wd_err != 0) begin
      errors++;
      $display("FAIL contention_addr_data: got rd_addr_err=%0d wr_addr_err=%0d hwdata_err=%0d expected 0 0 0", ra_err, wa_err, wd_err);
    end
    checks++;
    if (!seen_done || rd_count !== 32'd4 || wr_count !== 32'd3) begin
      errors++;
      $display("FAIL contention_counts: got done=%b rd=%0d wr=%0d expected 1 4 3", seen_done, rd_count, wr_count);
    end
  endtask

  task automatic test_wait_states();
    bit found = 1'b0, seen;
    int bad = 0;
    set_defaults();
    rd_addr      = 32'h0000_3001;
    end_of_image = 1'b1;
    HRDATA       = 32'hAABB_CCDD;
    pulse_start();
    for (int c = 0; c < 10 && !found; c++) begin
      if (HTRANS == HTRANS_NONSEQ) found = 1'b1; else tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_nonseq: got none expected a read within 10 cycles");
    end
    tick();
    HREADY = 1'b0;
    for (int w = 0; w < 3; w++) begin
      tick();
      if (HTRANS !== HTRANS_IDLE || pix_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wait_hold: got %0d bad cycles expected 0", bad);
    end
    HREADY = 1'b1;
    tick();
    checks++;
    if (pix_valid !== 1'b1 || pix_data !== 8'hCC || rd_count !== 32'd1) begin
      errors++;
      $display("FAIL wait_complete: got valid=%b data=%h rd=%0d expected 1 cc 1", pix_valid, pix_data, rd_count);
    end
    wait_done(10, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_done: got no done expected done within 10 cycles");
    end
  endtask

  task automatic test_backpressure();
    int ns = 0, nb = 0;
    bit found = 1'b0, seen;
    set_defaults();
    rd_addr      = 32'h40;
    end_of_image = 1'b1;
    pix_full     = 1'b1;
    pulse_start();
    for (int c = 0; c < 8; c++) begin
      if (HTRANS == HTRANS_NONSEQ) ns++;
      if (!busy) nb++;
      tick();
    end
    checks++;
    if (ns != 0 || nb != 0) begin
      errors++;
      $display("FAIL backpressure_hold: got nonseq=%0d not_busy=%0d expected 0 0", ns, nb);
    end
    pix_full = 1'b0;
    for (int c = 0; c < 5 && !found; c++) begin
      if (HTRANS == HTRANS_NONSEQ) found = 1'b1; else tick();
    end
    checks++;
    if (!found || HADDR !== 32'h40) begin
      errors++;
      $display("FAIL backpressure_resume: got found=%b addr=%h expected 1 00000040", found, HADDR);
    end
    wait_done(10, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL backpressure_done: got no done expected done within 10 cycles");
    end
  endtask

  task automatic test_bus_error();
    bit found = 1'b0, seen;
    int acks = 0, noerr = 0;
    set_defaults();
    rd_addr = 32'h80;
    wr_req  = 1'b1;
    wr_addr = 32'h5000;
    wr_data = 8'h5A;
    HRDATA  = 32'hFF;
    pulse_start();
    for (int c = 0; c < 20 && !found; c++) begin
      if (wr_ack) acks++;
      if (HTRANS == HTRANS_NONSEQ && HWRITE) found = 1'b1; else tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL buserr_nonseq: got none expected a write within 20 cycles");
    end
    tick();
    HREADY = 1'b0;
    HRESP  = 1'b1;
    tick();
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || HTRANS !== HTRANS_IDLE || rd_count !== 32'd1) begin
      errors++;
      $display("FAIL buserr_enter: got err=%b busy=%b htrans=%h rd=%0d expected 1 0 0 1", err, busy, HTRANS, rd_count);
    end
    HREADY = 1'b1;
    HRESP  = 1'b0;
    wr_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (wr_ack) acks++;
      if (!err) noerr++;
      tick();
    end
    checks++;
    if (acks != 0 || noerr != 0) begin
      errors++;
      $display("FAIL buserr_hold: got acks=%0d err_drops=%0d expected 0 0", acks, noerr);
    end
    pix_full = 1'b1;
    pulse_start();
    checks++;
    if (err !== 1'b0 || busy !== 1'b1 || rd_count !== 32'd0 || wr_count !== 32'd0) begin
      errors++;
      $display("FAIL buserr_restart: got err=%b busy=%b rd=%0d wr=%0d expected 0 1 0 0", err, busy, rd_count, wr_count);
    end
    pix_full     = 1'b0;
    end_of_image = 1'b1;
    wait_done(20, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL buserr_done: got no done expected done within 20 cycles");
    end
  endtask

  task automatic test_completion();
    int pv_c = -1, ack_c = -1, done_c = -1;
    set_defaults();
    rd_addr      = 32'h90;
    end_of_image = 1'b1;
    proc_busy    = 1'b1;
    wr_addr      = 32'h6000;
    wr_data      = 8'h77;
    pulse_start();
    for (int c = 0; c < 40 && done_c < 0; c++) begin
      if (pix_valid) pv_c = c;
      if (pv_c >= 0 && c == pv_c + 5) wr_req = 1'b1;
      if (wr_ack) begin ack_c = c; wr_req = 1'b0; proc_busy = 1'b0; end
      if (done) done_c = c;
      tick();
    end
    checks++;
    if (pv_c != 3 || ack_c != 11) begin
      errors++;
      $display("FAIL completion_events: got pix_cyc=%0d ack_cyc=%0d expected 3 11", pv_c, ack_c);
    end
    checks++;
    if (done_c != 13 || wr_count !== 32'd1) begin
      errors++;
      $display("FAIL completion_done: got done_cyc=%0d wr=%0d expected 13 1", done_c, wr_count);
    end
  endtask

  task automatic test_mid_reset();
    bit found = 1'b0;
    set_defaults();
    rd_addr      = 32'h0000_7000;
    end_of_image = 1'b1;
    pulse_start();
    for (int c = 0; c < 5 && !found; c++) begin
      if (HTRANS == HTRANS_NONSEQ) found = 1'b1; else tick();
    end
    #2 HRESETn = 1'b0;
    #1;
    checks++;
    if (!found || HTRANS !== HTRANS_IDLE || HADDR !== 32'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got found=%b htrans=%h haddr=%h busy=%b expected 1 0 0 0", found, HTRANS, HADDR, busy);
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || HTRANS !== HTRANS_IDLE) begin
      errors++;
      $display("FAIL mid_reset_idle: got busy=%b htrans=%h expected 0 0", busy, HTRANS);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_wait_states();
    test_backpressure();
    test_bus_error();
    test_completion();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
